// File: rtl/multi_channel_watchdog_pkg.sv
// -----------------------------------------------------------------------------
// multi_channel_watchdog_pkg
//
// Purpose : shared types and constants for the multi-channel watchdog.
//   wdt_state_e              - per-channel FSM state (also the debug view)
//   COMPLETE_BEATS_TIMEOUT   - a completion sampled on the terminal edge is
//                              on time and suppresses the timeout
//   START_BEATS_LATE_COMPLETE- in TIMEOUT, a start wins over a simultaneous
//                              (late) completion and re-arms the channel
// Ports   : none (package)
// -----------------------------------------------------------------------------
package multi_channel_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        TIMEOUT = 2'd2
    } wdt_state_e;

    localparam bit COMPLETE_BEATS_TIMEOUT    = 1'b1;
    localparam bit START_BEATS_LATE_COMPLETE = 1'b1;

endpackage

// File: rtl/multi_channel_watchdog_channel.sv
// -----------------------------------------------------------------------------
// watchdog_channel
//
// Purpose : one watchdog channel - FSM (IDLE/ACTIVE/TIMEOUT), cycle counter
//           and the limit latched when a start is accepted.
//
// Handshake: start and complete are single-cycle pulses sampled on every
//            rising edge; there is no back-pressure. Every output is a pulse
//            or level valid in the cycle it is driven, with no ready.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   start          in   start pulse
//   complete       in   completion pulse
//   limit          in   timeout limit in cycles (0 treated as 1), sampled on
//                       an accepted start only
//   busy           out  channel is ACTIVE
//   timeout_pulse  out  registered one-cycle timeout pulse
//   err_set        out  combinational: protocol error detected this cycle
//   to_set         out  combinational: timeout decided this cycle
//   state_dbg      out  current FSM state
// -----------------------------------------------------------------------------
module watchdog_channel
    import multi_channel_watchdog_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int RESTART_ON_START = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             complete,
    input  logic [CNT_W-1:0] limit,
    output logic             busy,
    output logic             timeout_pulse,
    output logic             err_set,
    output logic             to_set,
    output wdt_state_e       state_dbg
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               RESTART = (RESTART_ON_START != 0);

    wdt_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] lim, lim_nx;
    logic [CNT_W-1:0] lim_start;

    assign lim_start = (limit == '0) ? ONE : limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lim           <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            lim           <= lim_nx;
            timeout_pulse <= to_set;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lim_nx   = lim;
        err_set  = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: begin
                // Start alongside complete is an ordinary start, not an error.
                if (start) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                    lim_nx   = lim_start;
                end else if (complete) begin
                    err_set = 1'b1;
                end
            end
            ACTIVE: begin
                if (complete && start) begin
                    // Back-to-back: close this transaction, open the next.
                    cnt_nx = '0;
                    lim_nx = lim_start;
                end else if (complete && COMPLETE_BEATS_TIMEOUT) begin
                    state_nx = IDLE;
                end else if (start && RESTART) begin
                    cnt_nx = '0;
                    lim_nx = lim_start;
                end else begin
                    // An overlapping start is flagged but the original
                    // deadline keeps running.
                    if (start) begin
                        err_set = 1'b1;
                    end
                    // lim >= 1 whenever ACTIVE, so lim-1 never underflows and
                    // cnt reaches it before it could wrap.
                    if (cnt == lim - ONE) begin
                        state_nx = TIMEOUT;
                        to_set   = 1'b1;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
            end
            TIMEOUT: begin
                if (start && (START_BEATS_LATE_COMPLETE || !complete)) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                    lim_nx   = lim_start;
                end else if (complete) begin
                    // Late completion: already flagged, nothing more to add.
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy      = (state == ACTIVE);
    assign state_dbg = state;

endmodule

// File: rtl/multi_channel_watchdog.sv
// -----------------------------------------------------------------------------
// multi_channel_watchdog
//
// Purpose : NUM_CH independent request/complete watchdogs with per-channel
//           runtime limits, sticky clearable status, a saturating global
//           timeout counter and a level interrupt.
//
// Handshake: all inputs are sampled every rising edge with no back-pressure;
//            start/complete/sts_clr are single-cycle pulses, irq_en and
//            timeout_limit are levels. Outputs carry no ready.
//
// Ports:
//   clk                   in   clock
//   rst_n                 in   asynchronous active-low reset
//   start_transaction     in   [NUM_CH]        per-channel start pulse
//   complete_transaction  in   [NUM_CH]        per-channel completion pulse
//   timeout_limit         in   [NUM_CH*CNT_W]  per-channel limit, channel i at
//                                              bits [i*CNT_W +: CNT_W]
//   irq_en                in   [NUM_CH]        per-channel interrupt enable
//   sts_clr               in   [NUM_CH]        write-1-to-clear status
//   busy                  out  [NUM_CH]        channel ACTIVE
//   req_timeout           out  [NUM_CH]        one-cycle timeout pulse
//   timeout_sts           out  [NUM_CH]        sticky timeout flag
//   err_sts               out  [NUM_CH]        sticky protocol-error flag
//   timeout_count         out  [TOCNT_W]       saturating timeout total
//   irq                   out                  enabled status present
// -----------------------------------------------------------------------------
module multi_channel_watchdog
    import multi_channel_watchdog_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int CNT_W            = 8,
    parameter int TOCNT_W          = 16,
    parameter int RESTART_ON_START = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start_transaction,
    input  logic [NUM_CH-1:0]       complete_transaction,
    input  logic [NUM_CH*CNT_W-1:0] timeout_limit,
    input  logic [NUM_CH-1:0]       irq_en,
    input  logic [NUM_CH-1:0]       sts_clr,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       req_timeout,
    output logic [NUM_CH-1:0]       timeout_sts,
    output logic [NUM_CH-1:0]       err_sts,
    output logic [TOCNT_W-1:0]      timeout_count,
    output logic                    irq
);

    logic [NUM_CH-1:0] to_set;
    logic [NUM_CH-1:0] err_set;
    wdt_state_e        ch_state [NUM_CH];

    // Sum carries one extra bit to detect overflow. This is exact as long
    // as NUM_CH <= 2**TOCNT_W, which holds for every sensible configuration.
    logic [TOCNT_W:0]  to_inc;
    logic [TOCNT_W:0]  cnt_sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        watchdog_channel #(
            .CNT_W            (CNT_W),
            .RESTART_ON_START (RESTART_ON_START)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start_transaction[i]),
            .complete      (complete_transaction[i]),
            .limit         (timeout_limit[i*CNT_W +: CNT_W]),
            .busy          (busy[i]),
            .timeout_pulse (req_timeout[i]),
            .err_set       (err_set[i]),
            .to_set        (to_set[i]),
            .state_dbg     (ch_state[i])
        );

        a_busy_is_active: assert property (
            @(posedge clk) disable iff (!rst_n)
            busy[i] == (ch_state[i] == ACTIVE)
        );
    end

    // A set arriving with its clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_sts <= '0;
            err_sts     <= '0;
        end else begin
            timeout_sts <= (timeout_sts & ~sts_clr) | to_set;
            err_sts     <= (err_sts & ~sts_clr) | err_set;
        end
    end

    always_comb begin
        to_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            to_inc = to_inc + {{TOCNT_W{1'b0}}, req_timeout[i]};
        end
        cnt_sum = {1'b0, timeout_count} + to_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_count <= '0;
        end else if (cnt_sum[TOCNT_W]) begin
            timeout_count <= '1;
        end else begin
            timeout_count <= cnt_sum[TOCNT_W-1:0];
        end
    end

    assign irq = |((timeout_sts | err_sts) & irq_en);

endmodule

// File: tb/tb_multi_channel_watchdog.sv
module tb_multi_channel_watchdog;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start_transaction = '0;
    logic [3:0]  complete_transaction = '0;
    logic [3:0]  irq_en = '0;
    logic [3:0]  sts_clr = '0;
    logic [7:0]  lim_cfg [NCH];
    logic [31:0] timeout_limit;

    // main DUT: RESTART_ON_START=0, 16-bit counter
    logic [3:0]  busy, req_timeout, timeout_sts, err_sts;
    logic [15:0] timeout_count;
    logic        irq;
    // second DUT: RESTART_ON_START=1, 3-bit counter to reach saturation
    logic [3:0]  r_busy, r_req_timeout, r_timeout_sts, r_err_sts;
    logic [2:0]  r_timeout_count;
    logic        r_irq;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign timeout_limit = {lim_cfg[3], lim_cfg[2], lim_cfg[1], lim_cfg[0]};

    multi_channel_watchdog #(
        .NUM_CH(4), .CNT_W(8), .TOCNT_W(16), .RESTART_ON_START(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_transaction(start_transaction),
        .complete_transaction(complete_transaction),
        .timeout_limit(timeout_limit), .irq_en(irq_en), .sts_clr(sts_clr),
        .busy(busy), .req_timeout(req_timeout), .timeout_sts(timeout_sts),
        .err_sts(err_sts), .timeout_count(timeout_count), .irq(irq)
    );

    multi_channel_watchdog #(
        .NUM_CH(4), .CNT_W(8), .TOCNT_W(3), .RESTART_ON_START(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n),
        .start_transaction(start_transaction),
        .complete_transaction(complete_transaction),
        .timeout_limit(timeout_limit), .irq_en(irq_en), .sts_clr(sts_clr),
        .busy(r_busy), .req_timeout(r_req_timeout), .timeout_sts(r_timeout_sts),
        .err_sts(r_err_sts), .timeout_count(r_timeout_count), .irq(r_irq)
    );

    // ---------------- reference model ----------------
    // Each channel is tracked by its mode and the absolute edge number of its
    // deadline (start edge + effective limit).
    localparam int M_IDLE = 0, M_RUN = 1, M_LATE = 2;
    int          m_mode [2][NCH];
    longint      m_dl   [2][NCH];
    logic [3:0]  m_tsts [2];
    logic [3:0]  m_ests [2];
    logic [3:0]  m_rt   [2];
    int          m_cnt  [2];
    int          cmax   [2];
    bit          m_restart [2];
    longint      cyc;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_mode[d][c] = M_IDLE;
                m_dl[d][c]   = 0;
            end
            m_tsts[d] = '0;
            m_ests[d] = '0;
            m_rt[d]   = '0;
            m_cnt[d]  = 0;
        end
        cmax[0] = 65535;
        cmax[1] = 7;
        m_restart[0] = 1'b0;
        m_restart[1] = 1'b1;
    endtask

    function automatic int eff_lim(input int c);
        int l;
        l = int'(lim_cfg[c]);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic model_edge();
        logic [3:0] tset, eset;
        int         sum;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            sum = m_cnt[d] + $countones(m_rt[d]);
            m_cnt[d] = (sum > cmax[d]) ? cmax[d] : sum;
            tset = '0;
            eset = '0;
            for (int c = 0; c < NCH; c++) begin
                logic st, cp;
                st = start_transaction[c];
                cp = complete_transaction[c];
                if (m_mode[d][c] == M_IDLE) begin
                    if (st) begin
                        m_mode[d][c] = M_RUN;
                        m_dl[d][c]   = cyc + eff_lim(c);
                    end else if (cp) begin
                        eset[c] = 1'b1;
                    end
                end else if (m_mode[d][c] == M_RUN) begin
                    if (st && cp) begin
                        m_dl[d][c] = cyc + eff_lim(c);
                    end else if (cp) begin
                        m_mode[d][c] = M_IDLE;
                    end else if (st && m_restart[d]) begin
                        m_dl[d][c] = cyc + eff_lim(c);
                    end else begin
                        if (st) eset[c] = 1'b1;
                        if (cyc == m_dl[d][c]) begin
                            m_mode[d][c] = M_LATE;
                            tset[c] = 1'b1;
                        end
                    end
                end else begin
                    if (st) begin
                        m_mode[d][c] = M_RUN;
                        m_dl[d][c]   = cyc + eff_lim(c);
                    end else if (cp) begin
                        m_mode[d][c] = M_IDLE;
                    end
                end
            end
            m_tsts[d] = (m_tsts[d] & ~sts_clr) | tset;
            m_ests[d] = (m_ests[d] & ~sts_clr) | eset;
            m_rt[d]   = tset;
        end
    endtask

    function automatic logic [3:0] m_busy(input int d);
        logic [3:0] b;
        for (int c = 0; c < NCH; c++) b[c] = (m_mode[d][c] == M_RUN);
        return b;
    endfunction

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            exp_q.push_back({28'd0, m_busy(d)});
            exp_q.push_back({28'd0, m_rt[d]});
            exp_q.push_back({28'd0, m_tsts[d]});
            exp_q.push_back({28'd0, m_ests[d]});
            exp_q.push_back(32'(m_cnt[d]));
            exp_q.push_back({31'd0, |((m_tsts[d] | m_ests[d]) & irq_en)});
        end
        check("busy",          {28'd0, busy},          exp_q.pop_front());
        check("req_timeout",   {28'd0, req_timeout},   exp_q.pop_front());
        check("timeout_sts",   {28'd0, timeout_sts},   exp_q.pop_front());
        check("err_sts",       {28'd0, err_sts},       exp_q.pop_front());
        check("timeout_count", {16'd0, timeout_count}, exp_q.pop_front());
        check("irq",           {31'd0, irq},           exp_q.pop_front());
        check("r.busy",          {28'd0, r_busy},          exp_q.pop_front());
        check("r.req_timeout",   {28'd0, r_req_timeout},   exp_q.pop_front());
        check("r.timeout_sts",   {28'd0, r_timeout_sts},   exp_q.pop_front());
        check("r.err_sts",       {28'd0, r_err_sts},       exp_q.pop_front());
        check("r.timeout_count", {29'd0, r_timeout_count}, exp_q.pop_front());
        check("r.irq",           {31'd0, r_irq},           exp_q.pop_front());
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: drive, take the rising edge, then
    // compare at the next falling edge.
    task automatic cycle(input logic [3:0] st, input logic [3:0] cp, input logic [3:0] clr);
        start_transaction    = st;
        complete_transaction = cp;
        sts_clr              = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0, 4'b0, 4'b0);
    endtask

    task automatic reset_mid_run();
        start_transaction    = '0;
        complete_transaction = '0;
        sts_clr              = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst.busy_now", {28'd0, busy | r_busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_bits(input int pct);
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(99) < pct);
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        cyc = 0;
        for (int c = 0; c < NCH; c++) lim_cfg[c] = 8'd5;
        irq_en = 4'b1111;
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset.count", {16'd0, timeout_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 lim=5 completes at E3: busy for three cycles, nothing flagged
        bc = 0;
        cycle(4'b0001, 4'b0, 4'b0); bc += int'(busy[0]);
        cycle(4'b0, 4'b0, 4'b0);    bc += int'(busy[0]);
        cycle(4'b0, 4'b0, 4'b0);    bc += int'(busy[0]);
        cycle(4'b0, 4'b0001, 4'b0); bc += int'(busy[0]);
        check("t1.busy_cycles", 32'(bc), 32'd3);
        check("t1.flags", {28'd0, timeout_sts | err_sts}, 32'd0);

        // ch1 lim=5 never completes: pulse in the cycle after E5
        cycle(4'b0010, 4'b0, 4'b0);
        idle(4);
        check("t2.before_e5", {28'd0, req_timeout}, 32'd0);
        idle(1);
        check("t2.rt_pulse", {28'd0, req_timeout}, 32'h2);
        check("t2.sts", {28'd0, timeout_sts}, 32'h2);
        check("t2.irq", {31'd0, irq}, 32'd1);
        idle(1);
        check("t2.rt_one_cycle", {28'd0, req_timeout}, 32'd0);
        cycle(4'b0, 4'b0010, 4'b0);
        check("t2.late_sts", {28'd0, timeout_sts | err_sts}, 32'h2);

        // lim=0 on ch2 -> one cycle
        lim_cfg[2] = 8'd0;
        cycle(4'b0100, 4'b0, 4'b0);
        idle(1);
        check("t3.lim0", {28'd0, req_timeout}, 32'h4);

        // all four time out together, three rounds: main +4 each, r saturates
        for (int c = 0; c < NCH; c++) lim_cfg[c] = 8'd0;
        for (int r = 0; r < 3; r++) begin
            cycle(4'b1111, 4'b0, 4'b0);
            idle(1);
            check("t3.all_rt", {28'd0, req_timeout}, 32'hF);
            idle(1);
        end
        check("t3.count", {16'd0, timeout_count}, 32'd14);
        check("t3.sat", {29'd0, r_timeout_count}, 32'd7);

        // retire everything, clear, then spurious complete on idle ch3
        cycle(4'b0, 4'b1111, 4'b0);
        cycle(4'b0, 4'b0, 4'b1111);
        check("t4.cleared", {28'd0, timeout_sts | err_sts}, 32'd0);
        check("t4.irq_low", {31'd0, irq}, 32'd0);
        cycle(4'b0, 4'b1000, 4'b0);
        check("t4.spurious", {28'd0, err_sts}, 32'h8);

        // overlapping start on ch0, lim=4, second start at E2
        lim_cfg[0] = 8'd4;
        cycle(4'b0001, 4'b0, 4'b0);
        idle(1);
        cycle(4'b0001, 4'b0, 4'b0);
        check("t5.overlap_err", {28'd0, err_sts}, 32'h9);
        check("t5.restart_no_err", {28'd0, r_err_sts}, 32'h8);
        idle(2);
        check("t5.orig_deadline", {28'd0, req_timeout}, 32'h1);
        check("t5.restarted", {28'd0, r_req_timeout}, 32'h0);
        idle(2);
        check("t5.new_deadline", {28'd0, r_req_timeout}, 32'h1);

        // clear coincident with a new timeout on ch1 keeps the flag
        cycle(4'b0, 4'b0, 4'b1111);
        lim_cfg[1] = 8'd3;
        cycle(4'b0010, 4'b0, 4'b0);
        idle(2);
        cycle(4'b0, 4'b0, 4'b0010);
        check("t6.set_wins", {28'd0, timeout_sts}, 32'h2);
        cycle(4'b0, 4'b0, 4'b0010);
        check("t6.clr", {28'd0, timeout_sts}, 32'h0);
        check("t6.irq_drop", {31'd0, irq}, 32'd0);

        // reset in the middle of four active transactions
        for (int c = 0; c < NCH; c++) lim_cfg[c] = 8'd20;
        cycle(4'b1111, 4'b0, 4'b0);
        idle(3);
        reset_mid_run();
        idle(25);
        check("t7.no_stale", {16'd0, timeout_count}, 32'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++) lim_cfg[c] = 8'($urandom_range(9));
            if ($urandom_range(19) == 0) irq_en = 4'($urandom_range(15));
            if (i == 400) reset_mid_run();
            cycle(rnd_bits(15), rnd_bits(15), rnd_bits(8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
